// File: rtl/intr_ctrl.sv
// intr_ctrl: synchronise, edge-latch, mask and priority-encode interrupt lines into one registered request
module intr_ctrl #(
  parameter int N_SRC       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CAUSE_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic               INTC_CLK,
  input  logic               INTC_RST_N,
  input  logic [N_SRC-1:0]   INTC_IRQ_IN,
  input  logic [N_SRC-1:0]   INTC_EN_MASK,
  input  logic               INTC_MIE,
  input  logic               INTC_INT_TAKEN,
  input  logic               INTC_MRET_EXEC,
  input  logic               INTC_CLR_WE,
  input  logic [N_SRC-1:0]   INTC_CLR_DATA,
  output logic               INTC_INTR,
  output logic [CAUSE_W-1:0] INTC_CAUSE,
  output logic [N_SRC-1:0]   INTC_PENDING,
  output logic               INTC_IN_ISR
);
  typedef enum logic [1:0] {IDLE, REQ, ISR} state_e;
  state_e                            state_q, state_d;
  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
  logic [N_SRC-1:0]                  prev_q;
  logic [N_SRC-1:0]                  pend_q, pend_d;
  logic [N_SRC-1:0]                  elig, rise, clr;
  logic [CAUSE_W-1:0]                cause_q, cause_d, sel;
  logic                              intr_q, intr_d, isr_q, isr_d;

  assign rise         = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign elig         = pend_q & INTC_EN_MASK;
  assign INTC_INTR    = intr_q;
  assign INTC_CAUSE   = cause_q;
  assign INTC_PENDING = pend_q;
  assign INTC_IN_ISR  = isr_q;

  // lowest-index eligible source wins
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (elig[i]) sel = CAUSE_W'(i);
  end

  // pending update: software clear and trap-entry clear, with new edges overriding both
  always_comb begin
    clr    = ({N_SRC{INTC_CLR_WE}} & INTC_CLR_DATA)
           | ((state_q == REQ && INTC_INT_TAKEN) ? (N_SRC'(1) << cause_q) : '0);
    pend_d = (pend_q & ~clr) | rise;
  end

  // request FSM next state; outputs derive from the next state so they leave registered
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (|elig && INTC_MIE) ? REQ : IDLE;
      REQ:     state_d = INTC_INT_TAKEN ? ISR : ((!INTC_MIE || !(|elig)) ? IDLE : REQ);
      ISR:     state_d = INTC_MRET_EXEC ? IDLE : ISR;
      default: state_d = IDLE;
    endcase
    intr_d  = (state_d == REQ);
    isr_d   = (state_d == ISR);
    cause_d = (state_d == REQ) ? sel : cause_q;
  end

  // all state registers, cleared asynchronously
  always_ff @(posedge INTC_CLK or negedge INTC_RST_N) begin
    if (!INTC_RST_N) begin
      state_q <= IDLE;
      sync_q  <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      cause_q <= '0;
      intr_q  <= 1'b0;
      isr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], INTC_IRQ_IN};
      prev_q  <= sync_q[SYNC_STAGES-1];
      pend_q  <= pend_d;
      cause_q <= cause_d;
      intr_q  <= intr_d;
      isr_q   <= isr_d;
    end
  end
endmodule
